// File: rtl/ro_meas_ctrl_pkg.sv
// Shared types and helpers for the ring-oscillator measurement sequencer.
package ro_meas_ctrl_pkg;

  localparam int DEF_SETTLE = 16;
  localparam int DEF_GATE   = 1024;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } ro_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ro_meas_ctrl_if.sv
// Control/result bundle between the RO sequencer and its host logic.
interface ro_meas_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             start;
  logic             abort;
  logic             ro_out;
  logic             ro_activate;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output start, abort, ro_out,
    input  ro_activate, busy, done, count, overflow
  );

  modport slave (
    input  start, abort, ro_out,
    output ro_activate, busy, done, count, overflow
  );
endinterface

// File: rtl/ro_meas_ctrl_edge.sv
// Brings the asynchronous RO output into clk and emits a one-cycle pulse per rising edge.
module ro_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);
  logic [2:0] s_q;

  // s_q[1:0] is the metastability chain; s_q[2] holds the previous synchronized value
  always_ff @(posedge clk_i) begin
    if (rst_i) s_q <= '0;
    else       s_q <= {s_q[1:0], d_i};
  end

  assign rise_o = s_q[1] & ~s_q[2];
endmodule

// File: rtl/ro_meas_ctrl.sv
// RO frequency measurement: enable, settle, count edges over a fixed gate window, hold result.
module ro_meas_ctrl
  import ro_meas_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE,
  parameter int GATE_CYCLES   = DEF_GATE,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  ro_meas_ctrl_if.slave bus
);
  localparam int PH_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int PH_W   = clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]  SET_LD  = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0]  GATE_LD = PH_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ro_state_e        state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, res_q, res_d;
  logic             sat_q, sat_d, ovf_q, ovf_d, act_q, act_d;
  logic             ro_rise;

  ro_edge_sync u_sync (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .d_i    (bus.ro_out),
    .rise_o (ro_rise)
  );

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start && !bus.abort) begin
          state_d = ST_SETTLE;
          ph_d    = SET_LD;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (bus.abort) state_d = ST_IDLE;
        else if (ph_q == '0) begin
          state_d = ST_MEASURE;
          ph_d    = GATE_LD;
        end else ph_d = ph_q - PH_W'(1);
      end
      ST_MEASURE: begin
        if (bus.abort) state_d = ST_IDLE;
        else begin
          if (ro_rise) begin
            if (cnt_q == CNT_MAX) sat_d = 1'b1;
            else                  cnt_d = cnt_q + CNT_W'(1);
          end
          // result includes an edge seen in the final gate cycle
          if (ph_q == '0) begin
            state_d = ST_DONE;
            res_d   = cnt_d;
            ovf_d   = sat_d;
          end else ph_d = ph_q - PH_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign act_d = (state_d == ST_SETTLE) || (state_d == ST_MEASURE);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      act_q   <= act_d;
    end
  end

  assign bus.ro_activate = act_q;
  assign bus.busy        = (state_q == ST_SETTLE) || (state_q == ST_MEASURE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.count       = res_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Scoreboard bench for ro_meas_ctrl: two instances (wide and narrow counter) on a shared RO stimulus.
module tb_ro_meas_ctrl;
  localparam int S = 4;
  localparam int G = 64;

  typedef struct {
    logic [15:0] cnt;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ro_gen = 1'b0;
  logic ro_inj;
  int   ro_half;
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, act_cnt = 0;
  int   done_a_cnt = 0, done_b_cnt = 0, last_done_a = 0, done_gap_a = 0;
  logic prev_done_a = 1'b0;
  exp_t sb_a[$], sb_b[$];

  always #5 clk = ~clk;

  ro_meas_ctrl_if #(.CNT_W(16)) ifa ();
  ro_meas_ctrl_if #(.CNT_W(4))  ifb ();

  assign ifa.ro_out = ro_gen | ro_inj;
  assign ifb.ro_out = ro_gen | ro_inj;

  ro_meas_ctrl #(.SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  ro_meas_ctrl #(.SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // RO model: toggles every ro_half clk cycles, held low when ro_half is 0
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      if (ro_half == 0) begin
        ro_gen = 1'b0;
        ph = 0;
      end else if (ph >= ro_half - 1) begin
        ro_gen = ~ro_gen;
        ph = 0;
      end else ph++;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (ifa.ro_activate) act_cnt++;
      if (ifa.done) begin
        chk("done_a_1cyc", prev_done_a, 0);
        done_a_cnt++;
        done_gap_a  = cyc - last_done_a;
        last_done_a = cyc;
        if (sb_a.size() == 0) chk("sb_a_size", sb_a.size(), 1);
        else begin
          e = sb_a.pop_front();
          chk("count_a", ifa.count, e.cnt);
          chk("ovf_a", ifa.overflow, e.ovf);
        end
      end
      prev_done_a = ifa.done;
      if (ifb.done) begin
        done_b_cnt++;
        if (sb_b.size() == 0) chk("sb_b_size", sb_b.size(), 1);
        else begin
          e = sb_b.pop_front();
          chk("count_b", ifb.count, e.cnt);
          chk("ovf_b", ifb.overflow, e.ovf);
        end
      end
    end
  end

  task automatic wait_done_a(input int target, input int budget);
    int n;
    n = 0;
    while (done_a_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done_a", done_a_cnt >= target, 1);
  endtask

  task automatic wait_done_b(input int target, input int budget);
    int n;
    n = 0;
    while (done_b_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done_b", done_b_cnt >= target, 1);
  endtask

  initial begin
    int t0, tgt;
    rst_n = 1'b1;
    ifa.start = 0; ifa.abort = 0;
    ifb.start = 0; ifb.abort = 0;
    ro_half = 0; ro_inj = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_act", ifa.ro_activate, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_count", ifa.count, 0);
    chk("rst_ovf", ifa.overflow, 0);
    chk("rst_count_b", ifb.count, 0);

    // basic: edge every 8 clk over 64-cycle gate
    ro_half = 4;
    repeat (10) @(negedge clk);
    act_cnt = 0;
    ifa.start = 1; sb_a.push_back('{16'd8, 1'b0});
    @(negedge clk);
    ifa.start = 0; t0 = cyc;
    wait_done_a(1, 200);
    chk("latency", last_done_a - t0, S + G);
    chk("act_cycles", act_cnt, S + G);

    // saturation on the 4-bit instance: 16 edges in the window
    ro_half = 2;
    repeat (8) @(negedge clk);
    ifb.start = 1; sb_b.push_back('{16'd15, 1'b1});
    @(negedge clk);
    ifb.start = 0;
    wait_done_b(1, 200);

    // abort in MEASURE keeps previous result
    ro_half = 4;
    repeat (8) @(negedge clk);
    ifa.start = 1;
    @(negedge clk);
    ifa.start = 0;
    repeat (S + 9) @(negedge clk);
    ifa.abort = 1;
    @(negedge clk);
    ifa.abort = 0;
    chk("abort_act", ifa.ro_activate, 0);
    chk("abort_busy", ifa.busy, 0);
    chk("abort_count", ifa.count, 8);
    tgt = done_a_cnt;
    repeat (100) @(negedge clk);
    chk("abort_nodone", done_a_cnt, tgt);

    // abort wins over start in IDLE
    ifa.start = 1; ifa.abort = 1;
    @(negedge clk);
    ifa.start = 0; ifa.abort = 0;
    chk("abort_start_busy", ifa.busy, 0);
    chk("abort_start_act", ifa.ro_activate, 0);

    // RO stuck low
    ro_half = 0;
    repeat (10) @(negedge clk);
    tgt = done_a_cnt + 1;
    ifa.start = 1; sb_a.push_back('{16'd0, 1'b0});
    @(negedge clk);
    ifa.start = 0;
    wait_done_a(tgt, 200);

    // single RO rise landing in SETTLE must not be counted
    tgt = done_a_cnt + 1;
    ro_inj = 1; ifa.start = 1; sb_a.push_back('{16'd0, 1'b0});
    @(negedge clk);
    ifa.start = 0;
    repeat (2) @(negedge clk);
    ro_inj = 0;
    wait_done_a(tgt, 200);

    // start pulse during SETTLE ignored
    ro_half = 4;
    repeat (10) @(negedge clk);
    tgt = done_a_cnt + 1;
    ifa.start = 1; sb_a.push_back('{16'd8, 1'b0});
    @(negedge clk);
    ifa.start = 0;
    @(negedge clk);
    ifa.start = 1;
    @(negedge clk);
    ifa.start = 0;
    wait_done_a(tgt, 200);
    repeat (100) @(negedge clk);
    chk("settle_start_one_done", done_a_cnt, tgt);

    // start held: back-to-back runs
    tgt = done_a_cnt + 2;
    ifa.start = 1;
    sb_a.push_back('{16'd8, 1'b0});
    sb_a.push_back('{16'd8, 1'b0});
    wait_done_a(tgt - 1, 200);
    repeat (10) @(negedge clk);
    ifa.start = 0;
    wait_done_a(tgt, 200);
    chk("b2b_gap", done_gap_a, S + G + 1);
    repeat (100) @(negedge clk);
    chk("b2b_no_third", done_a_cnt, tgt);

    // reset in the middle of MEASURE
    ifa.start = 1;
    @(negedge clk);
    ifa.start = 0;
    repeat (S + 20) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    chk("mrst_act", ifa.ro_activate, 0);
    chk("mrst_busy", ifa.busy, 0);
    chk("mrst_done", ifa.done, 0);
    chk("mrst_count", ifa.count, 0);
    chk("mrst_ovf", ifa.overflow, 0);
    tgt = done_a_cnt;
    repeat (100) @(negedge clk);
    chk("mrst_nodone", done_a_cnt, tgt);
    chk("sb_a_drained", sb_a.size(), 0);
    chk("sb_b_drained", sb_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
